// File: rtl/idma_stream_fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | idma_stream_fifo_pkg: sizing helpers shared by the stream FIFO users |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package idma_stream_fifo_pkg;

  // Width needed to hold an occupancy count of 0..depth inclusive.
  function automatic int unsigned idma_fifo_usage_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/idma_fifo_wrap_ptr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | idma_fifo_wrap_ptr: pointer counting 0..Depth-1 with exact wrap      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module idma_fifo_wrap_ptr #(
  parameter int unsigned Depth     = 8,
  parameter int unsigned AddrDepth = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 inc_i,
  output logic [AddrDepth-1:0] ptr_o
);

  localparam logic [AddrDepth-1:0] c_last = AddrDepth'(Depth - 1);

  logic [AddrDepth-1:0] r_ptr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (clr_i) begin
      r_ptr <= '0;
    end else if (inc_i) begin
      r_ptr <= (r_ptr == c_last) ? '0 : r_ptr + AddrDepth'(1);
    end
  end

  assign ptr_o = r_ptr;

endmodule
`default_nettype wire

// File: rtl/idma_stream_fifo_thr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | idma_stream_fifo_thr: stream FIFO with occupancy count and           |
// | programmable almost-full/almost-empty flags, optional fall-through.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module idma_stream_fifo_thr
  import idma_stream_fifo_pkg::*;
#(
  parameter int unsigned Depth       = 8,
  parameter type         type_t      = logic,
  parameter bit          FallThrough = 1'b0,
  parameter bit          PrintInfo   = 1'b0,
  parameter int unsigned AddrDepth   = (Depth > 1) ? $clog2(Depth) : 1,
  parameter int unsigned UsageWidth  = idma_fifo_usage_width(Depth)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [UsageWidth-1:0] alm_full_thr_i,
  input  logic [UsageWidth-1:0] alm_empty_thr_i,
  output logic [UsageWidth-1:0] usage_o,
  output logic                  alm_full_o,
  output logic                  alm_empty_o,
  input  type_t                 data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output type_t                 data_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam logic [UsageWidth-1:0] c_depth = UsageWidth'(Depth);

  type_t                 r_mem [Depth];
  logic [UsageWidth-1:0] r_usage;
  logic [AddrDepth-1:0]  w_wr_ptr;
  logic [AddrDepth-1:0]  w_rd_ptr;
  logic                  w_empty;
  logic                  w_push_hs;
  logic                  w_pop_hs;
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_pop;

  assign w_empty = (r_usage == '0);

  // Reset is folded in so the handshake outputs drop as soon as rst_i rises.
  assign ready_o = (r_usage != c_depth) && !flush_i && !rst_i;

  generate
    if (FallThrough) begin : g_fall_through
      assign valid_o  = (!w_empty || valid_i) && !flush_i && !rst_i;
      assign data_o   = w_empty ? data_i : r_mem[w_rd_ptr];
      assign w_bypass = w_empty && w_push_hs && w_pop_hs;
    end else begin : g_registered
      assign valid_o  = !w_empty && !flush_i && !rst_i;
      assign data_o   = r_mem[w_rd_ptr];
      assign w_bypass = 1'b0;
    end
  endgenerate

  assign w_push_hs = valid_i && ready_o;
  assign w_pop_hs  = valid_o && ready_i;
  assign w_push    = w_push_hs && !w_bypass;
  assign w_pop     = w_pop_hs && !w_bypass;

  idma_fifo_wrap_ptr #(
    .Depth     (Depth),
    .AddrDepth (AddrDepth)
  ) u_wr_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (flush_i),
    .inc_i (w_push),
    .ptr_o (w_wr_ptr)
  );

  idma_fifo_wrap_ptr #(
    .Depth     (Depth),
    .AddrDepth (AddrDepth)
  ) u_rd_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (flush_i),
    .inc_i (w_pop),
    .ptr_o (w_rd_ptr)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_usage <= '0;
    end else if (flush_i) begin
      r_usage <= '0;
    end else if (w_push && !w_pop) begin
      r_usage <= r_usage + UsageWidth'(1);
    end else if (!w_push && w_pop) begin
      r_usage <= r_usage - UsageWidth'(1);
    end
  end

  // Payload storage carries no reset; data_o is only meaningful with valid_o.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[w_wr_ptr] <= data_i;
    end
  end

  assign usage_o     = r_usage;
  assign alm_full_o  = (r_usage >= alm_full_thr_i);
  assign alm_empty_o = (r_usage <= alm_empty_thr_i);

`ifndef SYNTHESIS
  generate
    if (Depth < 2) begin : g_depth_check
      $fatal(1, "idma_stream_fifo_thr: Depth must be at least 2");
    end
    if (PrintInfo) begin : g_print_info
      $info("idma_stream_fifo_thr: Depth=%0d FallThrough=%0d", Depth, FallThrough);
    end
  endgenerate

  a_push_ready: assert property (@(posedge clk_i) disable iff (rst_i) w_push |-> ready_o);
  a_pop_valid:  assert property (@(posedge clk_i) disable iff (rst_i) w_pop |-> valid_o);
  a_usage_max:  assert property (@(posedge clk_i) disable iff (rst_i) r_usage <= c_depth);
`endif

endmodule
`default_nettype wire

// File: tb/tb_idma_stream_fifo_thr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_idma_stream_fifo_thr: directed bench over three FIFO configs      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_idma_stream_fifo_thr;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vec  = 0;
  int errs = 0;

  // Depth 5, registered output
  logic       d5_flush = 0, d5_valid = 0, d5_ready = 0;
  logic [7:0] d5_data = '0, d5_data_o;
  logic [2:0] d5_full_thr = 3'd0, d5_empty_thr = 3'd1, d5_usage;
  logic       d5_alm_full, d5_alm_empty, d5_ready_o, d5_valid_o;

  // Depth 4, fall-through
  logic       d4_flush = 0, d4_valid = 0, d4_ready = 0;
  logic [7:0] d4_data = '0, d4_data_o;
  logic [2:0] d4_full_thr = 3'd4, d4_empty_thr = 3'd0, d4_usage;
  logic       d4_alm_full, d4_alm_empty, d4_ready_o, d4_valid_o;

  // Depth 8, registered output, thresholds 6 / 2
  logic       d8_flush = 0, d8_valid = 0, d8_ready = 0;
  logic [7:0] d8_data = '0, d8_data_o;
  logic [3:0] d8_full_thr = 4'd6, d8_empty_thr = 4'd2, d8_usage;
  logic       d8_alm_full, d8_alm_empty, d8_ready_o, d8_valid_o;

  idma_stream_fifo_thr #(.Depth(5), .type_t(logic [7:0]), .FallThrough(1'b0)) u_d5 (
    .clk_i(clk), .rst_i(rst), .flush_i(d5_flush),
    .alm_full_thr_i(d5_full_thr), .alm_empty_thr_i(d5_empty_thr),
    .usage_o(d5_usage), .alm_full_o(d5_alm_full), .alm_empty_o(d5_alm_empty),
    .data_i(d5_data), .valid_i(d5_valid), .ready_o(d5_ready_o),
    .data_o(d5_data_o), .valid_o(d5_valid_o), .ready_i(d5_ready)
  );

  idma_stream_fifo_thr #(.Depth(4), .type_t(logic [7:0]), .FallThrough(1'b1)) u_d4 (
    .clk_i(clk), .rst_i(rst), .flush_i(d4_flush),
    .alm_full_thr_i(d4_full_thr), .alm_empty_thr_i(d4_empty_thr),
    .usage_o(d4_usage), .alm_full_o(d4_alm_full), .alm_empty_o(d4_alm_empty),
    .data_i(d4_data), .valid_i(d4_valid), .ready_o(d4_ready_o),
    .data_o(d4_data_o), .valid_o(d4_valid_o), .ready_i(d4_ready)
  );

  idma_stream_fifo_thr #(.Depth(8), .type_t(logic [7:0]), .FallThrough(1'b0)) u_d8 (
    .clk_i(clk), .rst_i(rst), .flush_i(d8_flush),
    .alm_full_thr_i(d8_full_thr), .alm_empty_thr_i(d8_empty_thr),
    .usage_o(d8_usage), .alm_full_o(d8_alm_full), .alm_empty_o(d8_alm_empty),
    .data_i(d8_data), .valid_i(d8_valid), .ready_o(d8_ready_o),
    .data_o(d8_data_o), .valid_o(d8_valid_o), .ready_i(d8_ready)
  );

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    vec++; if (d5_ready_o !== 1'b0) begin errs++; $display("FAIL rst_ready: got %0b want 0", d5_ready_o); end
    vec++; if (d5_valid_o !== 1'b0) begin errs++; $display("FAIL rst_valid: got %0b want 0", d5_valid_o); end
    vec++; if (d5_usage !== 3'd0) begin errs++; $display("FAIL rst_usage: got %0d want 0", d5_usage); end
    vec++; if (d5_alm_empty !== 1'b1) begin errs++; $display("FAIL rst_alm_empty: got %0b want 1", d5_alm_empty); end
    vec++; if (d5_alm_full !== 1'b1) begin errs++; $display("FAIL rst_alm_full_thr0: got %0b want 1", d5_alm_full); end
    vec++; if (d8_alm_full !== 1'b0) begin errs++; $display("FAIL rst_alm_full_thr6: got %0b want 0", d8_alm_full); end
    tick();
    rst = 1'b0;
    tick();
    vec++; if (d5_ready_o !== 1'b1) begin errs++; $display("FAIL rst_release_ready: got %0b want 1", d5_ready_o); end
    vec++; if (d8_ready_o !== 1'b1) begin errs++; $display("FAIL rst_release_ready8: got %0b want 1", d8_ready_o); end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 5; i++) begin
      tick();
      d5_valid = 1'b1; d5_data = 8'(i);
      #1;
      vec++; if (d5_ready_o !== 1'b1) begin errs++; $display("FAIL fill_ready[%0d]: got %0b want 1", i, d5_ready_o); end
      vec++; if (d5_usage !== 3'(i - 1)) begin errs++; $display("FAIL fill_usage[%0d]: got %0d want %0d", i, d5_usage, i - 1); end
    end
    tick();
    d5_valid = 1'b0;
    #1;
    vec++; if (d5_ready_o !== 1'b0) begin errs++; $display("FAIL full_ready: got %0b want 0", d5_ready_o); end
    vec++; if (d5_usage !== 3'd5) begin errs++; $display("FAIL full_usage: got %0d want 5", d5_usage); end
    for (int i = 1; i <= 5; i++) begin
      tick();
      d5_ready = 1'b1;
      #1;
      vec++; if (d5_valid_o !== 1'b1) begin errs++; $display("FAIL drain_valid[%0d]: got %0b want 1", i, d5_valid_o); end
      vec++; if (d5_data_o !== 8'(i)) begin errs++; $display("FAIL drain_data[%0d]: got %0h want %0h", i, d5_data_o, i); end
    end
    tick();
    d5_ready = 1'b0;
    #1;
    vec++; if (d5_usage !== 3'd0) begin errs++; $display("FAIL drain_usage: got %0d want 0", d5_usage); end
    vec++; if (d5_valid_o !== 1'b0) begin errs++; $display("FAIL drain_valid_end: got %0b want 0", d5_valid_o); end
  endtask

  // Second pass of 7 items with overlapping push/pop so both pointers wrap.
  task automatic test_back_to_back();
    logic [7:0] q[$];
    bit         do_pop, do_push;
    for (int c = 0; c < 12; c++) begin
      tick();
      d5_valid = (c < 7);
      d5_data  = 8'h11 + 8'(c);
      d5_ready = (c >= 2);
      #1;
      vec++; if (d5_valid_o !== (q.size() != 0)) begin errs++; $display("FAIL b2b_valid[%0d]: got %0b want %0b", c, d5_valid_o, q.size() != 0); end
      if (q.size() != 0) begin
        vec++; if (d5_data_o !== q[0]) begin errs++; $display("FAIL b2b_data[%0d]: got %0h want %0h", c, d5_data_o, q[0]); end
      end
      do_pop  = d5_ready && (q.size() != 0);
      do_push = d5_valid && (q.size() < 5);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(d5_data);
    end
    tick();
    d5_valid = 1'b0; d5_ready = 1'b0;
    #1;
    vec++; if (d5_usage !== 3'd0) begin errs++; $display("FAIL b2b_usage: got %0d want 0", d5_usage); end
  endtask

  task automatic test_fall_through();
    tick();
    d4_valid = 1'b1; d4_data = 8'hA; d4_ready = 1'b1;
    #1;
    vec++; if (d4_valid_o !== 1'b1) begin errs++; $display("FAIL ft_valid: got %0b want 1", d4_valid_o); end
    vec++; if (d4_data_o !== 8'hA) begin errs++; $display("FAIL ft_data: got %0h want a", d4_data_o); end
    tick();
    d4_valid = 1'b0; d4_ready = 1'b0;
    #1;
    vec++; if (d4_usage !== 3'd0) begin errs++; $display("FAIL ft_usage: got %0d want 0", d4_usage); end
    vec++; if (d4_valid_o !== 1'b0) begin errs++; $display("FAIL ft_valid_after: got %0b want 0", d4_valid_o); end
  endtask

  task automatic test_full_pop_only();
    for (int i = 1; i <= 4; i++) begin
      tick();
      d4_valid = 1'b1; d4_data = 8'(i);
    end
    tick();
    d4_data = 8'h5; d4_ready = 1'b1;
    #1;
    vec++; if (d4_ready_o !== 1'b0) begin errs++; $display("FAIL fullpop_ready: got %0b want 0", d4_ready_o); end
    vec++; if (d4_data_o !== 8'h1) begin errs++; $display("FAIL fullpop_data: got %0h want 1", d4_data_o); end
    tick();
    d4_valid = 1'b0; d4_ready = 1'b0;
    #1;
    vec++; if (d4_usage !== 3'd3) begin errs++; $display("FAIL fullpop_usage: got %0d want 3", d4_usage); end
    for (int i = 2; i <= 4; i++) begin
      tick();
      d4_ready = 1'b1;
      #1;
      vec++; if (d4_data_o !== 8'(i)) begin errs++; $display("FAIL fullpop_drain[%0d]: got %0h want %0h", i, d4_data_o, i); end
    end
    tick();
    d4_ready = 1'b0;
    #1;
    vec++; if (d4_usage !== 3'd0) begin errs++; $display("FAIL fullpop_end_usage: got %0d want 0", d4_usage); end
  endtask

  task automatic test_thresholds();
    for (int k = 1; k <= 6; k++) begin
      tick();
      d8_valid = 1'b1; d8_data = 8'(k);
      #1;
      vec++; if (d8_alm_full !== 1'b0) begin errs++; $display("FAIL thr_full_low[%0d]: got %0b want 0", k, d8_alm_full); end
      vec++; if (d8_alm_empty !== (k - 1 <= 2)) begin errs++; $display("FAIL thr_empty_fill[%0d]: got %0b want %0b", k, d8_alm_empty, k - 1 <= 2); end
    end
    tick();
    d8_valid = 1'b0;
    #1;
    vec++; if (d8_usage !== 4'd6) begin errs++; $display("FAIL thr_usage6: got %0d want 6", d8_usage); end
    vec++; if (d8_alm_full !== 1'b1) begin errs++; $display("FAIL thr_full_rise: got %0b want 1", d8_alm_full); end
    for (int k = 6; k >= 3; k--) begin
      tick();
      d8_ready = 1'b1;
      #1;
      vec++; if (d8_alm_empty !== 1'b0) begin errs++; $display("FAIL thr_empty_low[%0d]: got %0b want 0", k, d8_alm_empty); end
      vec++; if (d8_data_o !== 8'(7 - k)) begin errs++; $display("FAIL thr_data[%0d]: got %0h want %0h", k, d8_data_o, 7 - k); end
    end
    tick();
    d8_ready = 1'b0;
    #1;
    vec++; if (d8_usage !== 4'd2) begin errs++; $display("FAIL thr_usage2: got %0d want 2", d8_usage); end
    vec++; if (d8_alm_empty !== 1'b1) begin errs++; $display("FAIL thr_empty_rise: got %0b want 1", d8_alm_empty); end
    vec++; if (d8_alm_full !== 1'b0) begin errs++; $display("FAIL thr_full_fall: got %0b want 0", d8_alm_full); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      tick();
      d8_valid = 1'b1; d8_data = 8'h40 + 8'(i);
    end
    tick();
    d8_valid = 1'b0;
    #1;
    vec++; if (d8_usage !== 4'd5) begin errs++; $display("FAIL flush_pre_usage: got %0d want 5", d8_usage); end
    tick();
    d8_flush = 1'b1; d8_valid = 1'b1; d8_data = 8'h55;
    #1;
    vec++; if (d8_ready_o !== 1'b0) begin errs++; $display("FAIL flush_ready: got %0b want 0", d8_ready_o); end
    vec++; if (d8_valid_o !== 1'b0) begin errs++; $display("FAIL flush_valid: got %0b want 0", d8_valid_o); end
    tick();
    d8_flush = 1'b0; d8_valid = 1'b0;
    #1;
    vec++; if (d8_usage !== 4'd0) begin errs++; $display("FAIL flush_usage: got %0d want 0", d8_usage); end
    tick();
    d8_valid = 1'b1; d8_data = 8'h77;
    tick();
    d8_valid = 1'b0; d8_ready = 1'b1;
    #1;
    vec++; if (d8_valid_o !== 1'b1) begin errs++; $display("FAIL flush_next_valid: got %0b want 1", d8_valid_o); end
    vec++; if (d8_data_o !== 8'h77) begin errs++; $display("FAIL flush_next_data: got %0h want 77", d8_data_o); end
    tick();
    d8_ready = 1'b0;
    #1;
    vec++; if (d8_usage !== 4'd0) begin errs++; $display("FAIL flush_end_usage: got %0d want 0", d8_usage); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      d5_valid = 1'b1; d5_data = 8'h31 + 8'(i);
    end
    tick();
    d5_data = 8'h34;
    #1;
    vec++; if (d5_usage !== 3'd3) begin errs++; $display("FAIL arst_pre_usage: got %0d want 3", d5_usage); end
    #1;
    rst = 1'b1;
    #1;
    vec++; if (d5_valid_o !== 1'b0) begin errs++; $display("FAIL arst_valid: got %0b want 0", d5_valid_o); end
    vec++; if (d5_usage !== 3'd0) begin errs++; $display("FAIL arst_usage: got %0d want 0", d5_usage); end
    vec++; if (d5_ready_o !== 1'b0) begin errs++; $display("FAIL arst_ready: got %0b want 0", d5_ready_o); end
    tick();
    #2;
    rst = 1'b0; d5_valid = 1'b0;
    tick();
    vec++; if (d5_ready_o !== 1'b1) begin errs++; $display("FAIL arst_release_ready: got %0b want 1", d5_ready_o); end
    vec++; if (d5_valid_o !== 1'b0) begin errs++; $display("FAIL arst_release_valid: got %0b want 0", d5_valid_o); end
    vec++; if (d5_usage !== 3'd0) begin errs++; $display("FAIL arst_release_usage: got %0d want 0", d5_usage); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_fall_through();
    test_full_pop_only();
    test_thresholds();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
`default_nettype wire
